// File: rtl/mprj_guard_ctrl.sv
// Power-up sequencer and wishbone watchdog for the management/user protection buffers.
// Orders user reset, settle and gate enable, and force-terminates stalled or disabled user accesses.
module mprj_guard_ctrl #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned TIMEOUT       = 255,
   parameter logic [31:0] TIMEOUT_DATA  = 32'hBADB_AD00
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        user_en_req,
   input  logic [63:0] la_iena_cfg,
   input  logic [2:0]  irq_ena_cfg,
   input  logic        mprj_cyc_o_core,
   input  logic        mprj_stb_o_core,
   input  logic        ack_i_gated,
   input  logic [31:0] dat_i_gated,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        mprj_iena_wb,
   output logic [63:0] la_iena_mprj,
   output logic [2:0]  user_irq_ena,
   output logic        user_rst_o,
   output logic        ready_o,
   output logic [2:0]  state_o,
   output logic [1:0]  err_o,
   input  logic        err_clr
);

   typedef enum logic [2:0] {
      S_OFF        = 3'd0,
      S_RESET_HOLD = 3'd1,
      S_SETTLE     = 3'd2,
      S_ON         = 3'd3,
      S_DRAIN      = 3'd4
   } state_e;

   localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] WD_LAST     = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  wd_q, wd_d;
   logic        force_q, force_d;
   logic [1:0]  err_q, err_d;
   logic [63:0] la_q, la_d;
   logic [2:0]  irq_q, irq_d;

   logic strobe, bus_open, pass_ack, any_ack;

   assign strobe   = mprj_cyc_o_core & mprj_stb_o_core;
   assign bus_open = (state_q == S_ON) || (state_q == S_DRAIN);
   // A pending forced ack owns its cycle; a coincident user ack is discarded.
   assign pass_ack = bus_open & strobe & ack_i_gated & ~force_q;
   assign any_ack  = force_q | pass_ack;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF: begin
            if (user_en_req) begin
               state_d = S_RESET_HOLD;
               cnt_d   = RST_LOAD;
            end
         end
         S_RESET_HOLD: begin
            if (!user_en_req) begin
               state_d = S_OFF;
            end else if (cnt_q == 8'd0) begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_SETTLE: begin
            if (!user_en_req) begin
               state_d = S_OFF;
            end else if (cnt_q == 8'd0) begin
               state_d = S_ON;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ON: begin
            if (!user_en_req) state_d = strobe ? S_DRAIN : S_OFF;
         end
         S_DRAIN: begin
            if (any_ack || !strobe) state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      wd_d    = '0;
      force_d = 1'b0;
      err_d   = err_q & ~{2{err_clr}};
      if (strobe && !force_q) begin
         if (!bus_open) begin
            force_d  = 1'b1;
            err_d[1] = 1'b1;
         end else if (!ack_i_gated) begin
            if (wd_q == WD_LAST) begin
               force_d  = 1'b1;
               err_d[0] = 1'b1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
      end
      la_d  = (state_d == S_ON) ? la_iena_cfg : '0;
      irq_d = (state_d == S_ON) ? irq_ena_cfg : '0;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wd_q    <= '0;
         force_q <= 1'b0;
         err_q   <= '0;
         la_q    <= '0;
         irq_q   <= '0;
      end else begin
         wd_q    <= wd_d;
         force_q <= force_d;
         err_q   <= err_d;
         la_q    <= la_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      user_rst_o   = (state_q == S_OFF) || (state_q == S_RESET_HOLD);
      mprj_iena_wb = bus_open;
      ready_o      = (state_q == S_ON);
      state_o      = state_q;
      la_iena_mprj = la_q;
      user_irq_ena = irq_q;
      err_o        = err_q;
      wb_ack_o     = any_ack;
      wb_dat_o     = force_q ? TIMEOUT_DATA : (pass_ack ? dat_i_gated : '0);
   end

endmodule

// File: tb/tb_mprj_guard_ctrl.sv
// Scoreboard bench for mprj_guard_ctrl: driver pushes expected acks, a monitor pops them on wb_ack_o.
// Sequencer timing is predicted from elapsed-cycle arithmetic on the configured delays.
module tb_mprj_guard_ctrl;

   localparam int          R  = 4;
   localparam int          S  = 2;
   localparam int          TO = 5;
   localparam logic [31:0] TD = 32'hBADB_AD00;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic        user_en_req;
   logic [63:0] la_iena_cfg;
   logic [2:0]  irq_ena_cfg;
   logic        mprj_cyc_o_core, mprj_stb_o_core;
   logic        ack_i_gated;
   logic [31:0] dat_i_gated;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        mprj_iena_wb;
   logic [63:0] la_iena_mprj;
   logic [2:0]  user_irq_ena;
   logic        user_rst_o, ready_o;
   logic [2:0]  state_o;
   logic [1:0]  err_o;
   logic        err_clr;

   mprj_guard_ctrl #(
      .RST_CYCLES(R), .SETTLE_CYCLES(S), .TIMEOUT(TO), .TIMEOUT_DATA(TD)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .user_en_req(user_en_req),
      .la_iena_cfg(la_iena_cfg), .irq_ena_cfg(irq_ena_cfg),
      .mprj_cyc_o_core(mprj_cyc_o_core), .mprj_stb_o_core(mprj_stb_o_core),
      .ack_i_gated(ack_i_gated), .dat_i_gated(dat_i_gated),
      .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .mprj_iena_wb(mprj_iena_wb),
      .la_iena_mprj(la_iena_mprj), .user_irq_ena(user_irq_ena),
      .user_rst_o(user_rst_o), .ready_o(ready_o), .state_o(state_o),
      .err_o(err_o), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc_n    = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [1:0]  exp_err = 2'b00;
   logic [63:0] cur_la  = '0;
   logic [2:0]  cur_irq = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic push_exp(input int c, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every presented ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!wb_rst_i) begin
         if (wb_ack_o) begin
            if (exp_q.size() == 0) begin
               check("ack_unexpected", 64'(wb_ack_o), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("ack_cycle", 64'(mon_e.cyc == cyc_n), 64'd1);
               check("ack_data", 64'(wb_dat_o), 64'(mon_e.data));
            end
         end else if (wb_dat_o !== 32'd0) begin
            check("dat_idle", 64'(wb_dat_o), 64'd0);
         end
      end
   end

   function automatic logic [2:0] exp_state_at(input int k);
      if (k < 1)         return 3'd0;
      if (k < 1 + R)     return 3'd1;
      if (k < 1 + R + S) return 3'd2;
      return 3'd3;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 64'(state_o), 64'd0);
      check({tag, "_urst"}, 64'(user_rst_o), 64'd1);
      check({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
      check({tag, "_dat"}, 64'(wb_dat_o), 64'd0);
      check({tag, "_iena_wb"}, 64'(mprj_iena_wb), 64'd0);
      check({tag, "_la"}, la_iena_mprj, 64'd0);
      check({tag, "_irq"}, 64'(user_irq_ena), 64'd0);
      check({tag, "_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
   endtask

   task automatic powerup(input logic [63:0] la, input logic [2:0] irq);
      tick();
      user_en_req = 1'b1;
      la_iena_cfg = la;
      irq_ena_cfg = irq;
      for (int k = 0; k <= R + S + 1; k++) begin
         sample();
         check("pu_state", 64'(state_o), 64'(exp_state_at(k)));
         check("pu_urst", 64'(user_rst_o), 64'(k < 1 + R));
         check("pu_ready", 64'(ready_o), 64'(k >= 1 + R + S));
         check("pu_iena_wb", 64'(mprj_iena_wb), 64'(k >= 1 + R + S));
         check("pu_la", la_iena_mprj, (k >= 1 + R + S) ? la : 64'd0);
         tick();
      end
      check("pu_irq", 64'(user_irq_ena), 64'(irq));
      cur_la  = la;
      cur_irq = irq;
   endtask

   // One user transfer starting in the current cycle; user ack at strobe cycle d (never if d > TO).
   task automatic xfer(input int d, input logic [31:0] data);
      int c0;
      int last;
      c0 = cyc_n;
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      if (d <= TO) begin
         last = d;
         push_exp(c0 + d - 1, data);
      end else begin
         last = TO + 1;
         push_exp(c0 + TO, TD);
         exp_err[0] = 1'b1;
      end
      for (int k = 1; k <= last; k++) begin
         ack_i_gated = (k == d);
         dat_i_gated = (k == d) ? data : $urandom;
         tick();
      end
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      ack_i_gated     = 1'($urandom);
      dat_i_gated     = $urandom;
   endtask

   task automatic cfg_change();
      logic [63:0] nl;
      logic [2:0]  ni;
      nl = {$urandom, $urandom};
      ni = 3'($urandom);
      la_iena_cfg = nl;
      irq_ena_cfg = ni;
      sample();
      check("cfg_la_hold", la_iena_mprj, cur_la);
      tick();
      sample();
      check("cfg_la_new", la_iena_mprj, nl);
      check("cfg_irq_new", 64'(user_irq_ena), 64'(ni));
      cur_la  = nl;
      cur_irq = ni;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL time_limit: simulation did not reach its summary");
      $fatal(1, "time limit");
   end

   initial begin
      int          d;
      int          gap;
      int          c;
      logic [31:0] data;

      wb_rst_i        = 1'b1;
      user_en_req     = 1'b0;
      la_iena_cfg     = '0;
      irq_ena_cfg     = '0;
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      ack_i_gated     = 1'b0;
      dat_i_gated     = '0;
      err_clr         = 1'b0;

      sample();
      check_reset_values("rst");
      tick();
      wb_rst_i = 1'b0;

      // Disabled access in OFF, then clear.
      tick();
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      ack_i_gated     = 1'b1;
      dat_i_gated     = $urandom;
      push_exp(cyc_n + 1, TD);
      exp_err[1] = 1'b1;
      tick();
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      ack_i_gated     = 1'b0;
      sample();
      check("dis_err", 64'(err_o), 64'(exp_err));
      tick();
      err_clr = 1'b1;
      exp_err = 2'b00;
      tick();
      err_clr = 1'b0;
      sample();
      check("dis_err_clr", 64'(err_o), 64'(exp_err));

      // Error set and clear in the same cycle: the set survives.
      tick();
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      err_clr         = 1'b1;
      push_exp(cyc_n + 1, TD);
      exp_err = 2'b10;
      tick();
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      err_clr         = 1'b0;
      sample();
      check("set_wins_err", 64'(err_o), 64'(exp_err));

      // Strobe held three cycles while disabled: two separate transfers, two forced acks.
      tick();
      c = cyc_n;
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      push_exp(c + 1, TD);
      push_exp(c + 3, TD);
      tick();
      tick();
      tick();
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      tick();
      err_clr = 1'b1;
      exp_err = 2'b00;
      tick();
      err_clr = 1'b0;

      // Abort during RESET_HOLD.
      tick();
      user_en_req = 1'b1;
      tick();
      tick();
      user_en_req = 1'b0;
      sample();
      check("abort_rh_state", 64'(state_o), 64'd1);
      tick();
      sample();
      check("abort_off_state", 64'(state_o), 64'd0);
      check("abort_off_urst", 64'(user_rst_o), 64'd1);

      powerup(64'hFFFF_0000_FFFF_0000, 3'b101);

      // Normal read with user ack at strobe cycle 3.
      xfer(3, 32'h1234_5678);
      sample();
      check("read_err", 64'(err_o), 64'd0);

      // Timeout, then a user ack at strobe-cycle-8 position with strobe low is masked.
      xfer(TO + 3, 32'h0);
      tick();
      ack_i_gated = 1'b1;
      dat_i_gated = 32'hDEAD_BEEF;
      sample();
      check("timeout_err", 64'(err_o), 64'b01);
      tick();
      ack_i_gated = 1'b0;
      err_clr     = 1'b1;
      exp_err     = 2'b00;
      tick();
      err_clr = 1'b0;

      // Randomised transfers and config changes while ON.
      for (int i = 0; i < 40; i++) begin
         d    = $urandom_range(1, TO + 2);
         data = $urandom;
         xfer(d, data);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            ack_i_gated = 1'($urandom);
            dat_i_gated = $urandom;
            tick();
         end
         ack_i_gated = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            mprj_cyc_o_core = 1'b0;
            mprj_stb_o_core = 1'b0;
            cfg_change();
         end
      end
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      tick();
      sample();
      check("rand_err", 64'(err_o), 64'(exp_err));
      check("rand_state", 64'(state_o), 64'd3);

      // Disable during a transfer: DRAIN, user ack passes, then OFF.
      tick();
      c    = cyc_n;
      data = $urandom;
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      ack_i_gated     = 1'b0;
      user_en_req     = 1'b0;
      push_exp(c + 1, data);
      sample();
      check("drain_pre_state", 64'(state_o), 64'd3);
      tick();
      ack_i_gated = 1'b1;
      dat_i_gated = data;
      sample();
      check("drain_state", 64'(state_o), 64'd4);
      check("drain_la", la_iena_mprj, 64'd0);
      check("drain_irq", 64'(user_irq_ena), 64'd0);
      check("drain_iena_wb", 64'(mprj_iena_wb), 64'd1);
      tick();
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      ack_i_gated     = 1'b0;
      sample();
      check("drain_off_state", 64'(state_o), 64'd0);
      check("drain_off_iena_wb", 64'(mprj_iena_wb), 64'd0);

      // Disable while ON and idle.
      powerup({$urandom, $urandom}, 3'($urandom));
      user_en_req = 1'b0;
      sample();
      check("idle_dis_pre", 64'(state_o), 64'd3);
      tick();
      sample();
      check("idle_dis_state", 64'(state_o), 64'd0);
      check("idle_dis_la", la_iena_mprj, 64'd0);
      check("idle_dis_irq", 64'(user_irq_ena), 64'd0);
      check("idle_dis_urst", 64'(user_rst_o), 64'd1);
      check("idle_dis_iena_wb", 64'(mprj_iena_wb), 64'd0);

      // Asynchronous reset in the middle of a stalled transfer drops the pending forced ack.
      powerup({$urandom, $urandom}, 3'($urandom));
      mprj_cyc_o_core = 1'b1;
      mprj_stb_o_core = 1'b1;
      ack_i_gated     = 1'b0;
      tick();
      tick();
      tick();
      #2;
      wb_rst_i = 1'b1;
      #1;
      exp_err = 2'b00;
      check_reset_values("arst");
      for (int k = 0; k < TO + 2; k++) tick();
      mprj_cyc_o_core = 1'b0;
      mprj_stb_o_core = 1'b0;
      user_en_req     = 1'b0;
      tick();
      wb_rst_i = 1'b0;
      for (int k = 0; k < TO + 2; k++) tick();
      sample();
      check("arst_after_state", 64'(state_o), 64'd0);
      check("arst_after_err", 64'(err_o), 64'd0);

      tick();
      check("pending_acks", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
